// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM states and default line/clock constants.
// The future transmitter imports the same package.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd3,
    ST_BREAK = 3'd4
  } uart_rx_state_t;

  localparam int unsigned UART_CLK_FREQ = 27_000_000;
  localparam int unsigned UART_BAUD     = 115_200;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input; reset value selectable so
// idle-high lines (UART rx, keys) come out of reset without a false edge.
module sync_2ff #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/uart_receiver.sv
// 8N1 UART receiver: mid-bit sampling off a synchronized line, one-byte holding
// register with valid/ready hand-off, frame-error and overrun pulses.
module uart_receiver
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ = UART_CLK_FREQ,
  parameter int unsigned BAUD     = UART_BAUD
) (
  input  logic       clk,
  input  logic       key_rst,
  input  logic       uart_rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       rx_frame_err,
  output logic       rx_overrun,
  output logic [2:0] dbg_state
);

  localparam int unsigned CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int unsigned CNT_W        = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);

  if (CLKS_PER_BIT < 4) begin : g_bad_rate
    $error("uart_receiver: CLK_FREQ/BAUD must be at least 4");
  end

  logic rxs;

  sync_2ff #(.RST_VAL(1'b1)) u_sync (
    .clk   (clk),
    .rst_n (key_rst),
    .d_i   (uart_rx),
    .q_o   (rxs)
  );

  uart_rx_state_t   state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shift_q, shift_d;
  logic [7:0]       data_q, data_d;
  logic             valid_q, valid_d;
  logic             fe_q, fe_d;
  logic             ovr_q, ovr_d;

  always_ff @(posedge clk or negedge key_rst) begin
    if (!key_rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      fe_q    <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      fe_q    <= fe_d;
      ovr_q   <= ovr_d;
    end
  end

  // Handshake: a byte transfers on a rising edge with rx_valid & rx_ready; rx_valid
  // then drops unless a new byte lands on that same edge. rx_data never changes
  // while a byte is offered and not yet taken; a byte arriving then is dropped.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    data_d  = data_q;
    valid_d = valid_q;
    fe_d    = 1'b0;
    ovr_d   = 1'b0;

    if (valid_q && rx_ready) begin
      valid_d = 1'b0;
    end

    unique case (state_q)
      ST_IDLE: begin
        if (!rxs) begin
          state_d = ST_START;
          cnt_d   = '0;
        end
      end
      ST_START: begin
        if (cnt_q == HALF_M1) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = rxs ? ST_IDLE : ST_DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_DATA: begin
        if (cnt_q == FULL_M1) begin
          cnt_d   = '0;
          shift_d = {rxs, shift_q[7:1]};
          bit_d   = bit_q + 1'b1;
          if (bit_q == 3'd7) begin
            state_d = ST_STOP;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_STOP: begin
        if (cnt_q == FULL_M1) begin
          cnt_d = '0;
          if (rxs) begin
            state_d = ST_IDLE;
            if (!valid_q || rx_ready) begin
              data_d  = shift_q;
              valid_d = 1'b1;
            end else begin
              ovr_d = 1'b1;
            end
          end else begin
            fe_d    = 1'b1;
            state_d = ST_BREAK;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_BREAK: begin
        if (rxs) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign rx_data      = data_q;
  assign rx_valid     = valid_q;
  assign rx_frame_err = fe_q;
  assign rx_overrun   = ovr_q;
  assign dbg_state    = state_q;

endmodule
